// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PEND  = 2'd2,
    STALL = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned PC_STEP       = 4;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator with valid/ready fetch handshake, stall hold,
// deferred redirects and kill pulse. Optional jump alignment check: PC_ALIGN_CHK_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR),
  parameter int unsigned      STEP       = PC_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             jump_en_i,
  input  logic [WIDTH-1:0] jump_addr_i,
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] fetch_addr_o,
  input  logic             fetch_ready_i,
  output logic             fetch_kill_o,
  output logic             misalign_o
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             valid_d;
  logic             kill_d;
  logic             accept;
  logic             jump_ok;

  assign accept = fetch_valid_o & fetch_ready_i;

`ifdef PC_ALIGN_CHK_EN
  logic misalign_d;
  logic misalign_q;

  assign jump_ok    = jump_en_i & (jump_addr_i[1:0] == 2'b00);
  assign misalign_d = jump_en_i & (jump_addr_i[1:0] != 2'b00);
  assign misalign_o = misalign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign jump_ok    = jump_en_i;
  assign misalign_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        state_d = stall_i ? STALL : REQ;
        if (jump_ok) addr_d = jump_addr_i;
      end
      REQ: begin
        if (accept) begin
          addr_d  = jump_ok ? jump_addr_i : addr_q + WIDTH'(STEP);
          state_d = stall_i ? STALL : REQ;
        end else if (jump_ok) begin
          // Outstanding request must stay stable; park the redirect target.
          pend_d  = jump_addr_i;
          state_d = PEND;
        end
      end
      PEND: begin
        if (jump_ok) pend_d = jump_addr_i;
        if (accept) begin
          addr_d  = jump_ok ? jump_addr_i : pend_q;
          state_d = stall_i ? STALL : REQ;
        end
      end
      STALL: begin
        if (jump_ok)  addr_d  = jump_addr_i;
        if (!stall_i) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == REQ) || (state_d == PEND);
    // The request accepted out of PEND points at the pre-redirect stream.
    kill_d  = jump_ok | ((state_q == PEND) & accept);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= RESET_ADDR;
      pend_q        <= '0;
      fetch_valid_o <= 1'b0;
      fetch_kill_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      pend_q        <= pend_d;
      fetch_valid_o <= valid_d;
      fetch_kill_o  <= kill_d;
    end
  end

  assign fetch_addr_o = addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; expectations follow PC_ALIGN_CHK_EN when defined.
module tb_pc_gen;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall_i;
  logic         jump_en_i;
  logic [W-1:0] jump_addr_i;
  logic         fetch_valid_o;
  logic [W-1:0] fetch_addr_o;
  logic         fetch_ready_i;
  logic         fetch_kill_o;
  logic         misalign_o;

  int total = 0;
  int bad   = 0;

  pc_gen #(.WIDTH(W), .RESET_ADDR(32'h0000_0000), .STEP(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .jump_en_i     (jump_en_i),
    .jump_addr_i   (jump_addr_i),
    .fetch_valid_o (fetch_valid_o),
    .fetch_addr_o  (fetch_addr_o),
    .fetch_ready_i (fetch_ready_i),
    .fetch_kill_o  (fetch_kill_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; fetch_ready_i = 1'b0;
    tick(); tick();
    total++; if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", fetch_valid_o); end
    total++; if (fetch_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=00000000", fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b0) begin bad++; $display("FAIL rst_kill got=%b exp=0", fetch_kill_o); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_o); end
    rst_n = 1'b1;
    tick();
    total++; if (fetch_valid_o !== 1'b1) begin bad++; $display("FAIL idle_to_req_valid got=%b exp=1", fetch_valid_o); end
    total++; if (fetch_addr_o !== 32'h0) begin bad++; $display("FAIL idle_to_req_addr got=%h exp=00000000", fetch_addr_o); end
  endtask

  task automatic test_sequential();
    logic [W-1:0] exp_addr;
    fetch_ready_i = 1'b1;
    exp_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_addr = exp_addr + 32'd4;
      total++; if (fetch_addr_o !== exp_addr) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, fetch_addr_o, exp_addr); end
      total++; if (fetch_valid_o !== 1'b1 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL seq_valid_kill[%0d] got=%b%b exp=10", i, fetch_valid_o, fetch_kill_o); end
    end
  endtask

  task automatic test_deferred_jump();
    fetch_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h200;
    tick();
    total++; if (fetch_addr_o !== 32'h10) begin bad++; $display("FAIL pend_hold_addr got=%h exp=00000010", fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL pend_jump_kill got=%b exp=1", fetch_kill_o); end
    jump_en_i = 1'b0;
    tick(); tick();
    total++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h10) begin bad++; $display("FAIL pend_still_held got=%b/%h exp=1/00000010", fetch_valid_o, fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b0) begin bad++; $display("FAIL pend_kill_idle got=%b exp=0", fetch_kill_o); end
    fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    total++; if (fetch_addr_o !== 32'h200) begin bad++; $display("FAIL pend_redirect_addr got=%h exp=00000200", fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL pend_accept_kill got=%b exp=1", fetch_kill_o); end
    total++; if (fetch_valid_o !== 1'b1) begin bad++; $display("FAIL pend_after_valid got=%b exp=1", fetch_valid_o); end
  endtask

  task automatic test_stall();
    fetch_ready_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h20;
    tick();
    total++; if (fetch_addr_o !== 32'h20) begin bad++; $display("FAIL acc_jump_addr got=%h exp=00000020", fetch_addr_o); end
    jump_en_i = 1'b0; stall_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    total++; if (fetch_valid_o !== 1'b0 || fetch_addr_o !== 32'h24) begin bad++; $display("FAIL stall_entry got=%b/%h exp=0/00000024", fetch_valid_o, fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b0) begin bad++; $display("FAIL stall_entry_kill got=%b exp=0", fetch_kill_o); end
    jump_en_i = 1'b1; jump_addr_i = 32'h80;
    tick();
    jump_en_i = 1'b0;
    total++; if (fetch_valid_o !== 1'b0 || fetch_addr_o !== 32'h80) begin bad++; $display("FAIL stall_jump got=%b/%h exp=0/00000080", fetch_valid_o, fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL stall_jump_kill got=%b exp=1", fetch_kill_o); end
    tick();
    total++; if (fetch_valid_o !== 1'b0 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b%b exp=00", fetch_valid_o, fetch_kill_o); end
    stall_i = 1'b0;
    tick();
    total++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h80) begin bad++; $display("FAIL stall_release got=%b/%h exp=1/00000080", fetch_valid_o, fetch_addr_o); end
  endtask

  task automatic test_double_jump();
    fetch_ready_i = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h100;
    tick();
    jump_addr_i = 32'h300;
    tick();
    total++; if (fetch_addr_o !== 32'h80 || fetch_kill_o !== 1'b1) begin bad++; $display("FAIL dbl_pend got=%h/%b exp=00000080/1", fetch_addr_o, fetch_kill_o); end
    jump_en_i = 1'b0; fetch_ready_i = 1'b1;
    tick();
    fetch_ready_i = 1'b0;
    total++; if (fetch_addr_o !== 32'h300) begin bad++; $display("FAIL dbl_latest_wins got=%h exp=00000300", fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL dbl_accept_kill got=%b exp=1", fetch_kill_o); end
  endtask

  task automatic test_wrap();
    fetch_ready_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_en_i = 1'b0;
    total++; if (fetch_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_setup got=%h exp=fffffffc", fetch_addr_o); end
    tick();
    fetch_ready_i = 1'b0;
    total++; if (fetch_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=00000000", fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b0) begin bad++; $display("FAIL wrap_kill got=%b exp=0", fetch_kill_o); end
  endtask

  task automatic test_align();
    logic [W-1:0] exp_a1, exp_a2;
    logic         exp_mis, exp_kill;
`ifdef PC_ALIGN_CHK_EN
    exp_a1 = 32'h4;   exp_a2 = 32'h8;   exp_mis = 1'b1; exp_kill = 1'b0;
`else
    exp_a1 = 32'h102; exp_a2 = 32'h106; exp_mis = 1'b0; exp_kill = 1'b1;
`endif
    fetch_ready_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h102;
    tick();
    jump_en_i = 1'b0;
    total++; if (fetch_addr_o !== exp_a1) begin bad++; $display("FAIL align_addr got=%h exp=%h", fetch_addr_o, exp_a1); end
    total++; if (misalign_o !== exp_mis) begin bad++; $display("FAIL align_misalign got=%b exp=%b", misalign_o, exp_mis); end
    total++; if (fetch_kill_o !== exp_kill) begin bad++; $display("FAIL align_kill got=%b exp=%b", fetch_kill_o, exp_kill); end
    tick();
    fetch_ready_i = 1'b0;
    total++; if (fetch_addr_o !== exp_a2) begin bad++; $display("FAIL align_next_addr got=%h exp=%h", fetch_addr_o, exp_a2); end
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL align_pulse_end got=%b exp=0", misalign_o); end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick();
    total++; if (fetch_valid_o !== 1'b0 || fetch_addr_o !== 32'h0) begin bad++; $display("FAIL midrst got=%b/%h exp=0/00000000", fetch_valid_o, fetch_addr_o); end
    rst_n = 1'b1; stall_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h40;
    tick();
    total++; if (fetch_valid_o !== 1'b0 || fetch_addr_o !== 32'h40) begin bad++; $display("FAIL idle_stall_jump got=%b/%h exp=0/00000040", fetch_valid_o, fetch_addr_o); end
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL idle_jump_kill got=%b exp=1", fetch_kill_o); end
    jump_en_i = 1'b0; stall_i = 1'b0;
    tick();
    total++; if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h40 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL idle_stall_release got=%b/%h/%b exp=1/00000040/0", fetch_valid_o, fetch_addr_o, fetch_kill_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_deferred_jump();
    test_stall();
    test_double_jump();
    test_wrap();
    test_align();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V fetch stage.
- Successor to the free-running PC register; adds a configurable reset vector and step, and a valid/ready fetch handshake to the instruction bus.
- Adds stall hold from ctrl, deferred redirects while a request is pending, and a kill pulse so the fetch/IF-ID logic drops stale instructions.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.
- STEP, 4, increment in bytes per accepted fetch.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- stall_i  input  1  from ctrl; blocks issue of new fetch requests.
- jump_en_i  input  1  from ctrl; redirect request.
- jump_addr_i  input  WIDTH  from ctrl; redirect target.
- fetch_valid_o  output  1  fetch request valid.
- fetch_addr_o  output  WIDTH  fetch address.
- fetch_ready_i  input  1  bus accepts request.
- fetch_kill_o  output  1  one-cycle pulse; all responses to previously accepted requests are stale.
- misalign_o  output  1  misaligned-jump pulse (PC_ALIGN_CHK_EN only; tied 0 otherwise).

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, fetch_valid_o=0, fetch_addr_o=RESET_ADDR, fetch_kill_o=0, misalign_o=0, pend_addr=0.
- Terms: accept = fetch_valid_o & fetch_ready_i. All outputs are registered.
- fetch_valid_o=1 exactly in states REQ and PEND. fetch_addr_o never changes while fetch_valid_o=1 and accept=0.
- State IDLE (one cycle after reset):
  - Next state is REQ if stall_i=0, else STALL.
  - jump_en_i=1 sets fetch_addr_o <= jump_addr_i.
- State REQ:
  - accept & !jump_en_i: addr <= addr+STEP; go to STALL if stall_i, else stay in REQ.
  - accept & jump_en_i: addr <= jump_addr_i; go to STALL if stall_i, else stay in REQ.
  - !accept & jump_en_i: pend_addr <= jump_addr_i; go to PEND; addr held.
  - !accept & !jump_en_i: hold.
  - stall_i never drops fetch_valid_o once it is asserted.
- State PEND:
  - jump_en_i overwrites pend_addr (latest redirect wins).
  - On accept: addr <= jump_addr_i if jump_en_i, else pend_addr; go to STALL if stall_i, else REQ.
- State STALL:
  - fetch_valid_o=0.
  - jump_en_i sets addr <= jump_addr_i.
  - stall_i=0 moves to REQ the next cycle.
- Priority: jump beats stall for address update; stall still suppresses valid.
- fetch_kill_o=1 in the cycle after:
  - any cycle with jump_en_i=1, in any state; or
  - acceptance of the held request in PEND, since that request is stale.
- Arithmetic: addr+STEP wraps modulo 2^WIDTH (e.g. 0xFFFF_FFFC+4 -> 0x0000_0000); no carry out.
- Reset asserted mid-request: request abandoned; fetch_valid_o drops the next cycle without handshake; bus must tolerate this.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - jump_en_i with jump_addr_i[1:0]!=0 is ignored; it causes no address change, no PEND entry and no kill.
  - misalign_o pulses 1 the next cycle.
  - Aligned jumps behave as above.
- Undefined: all jumps are taken unchanged; misalign_o is constant 0.

Decomposition:
- Package pc_pkg holds:
  - state enum pc_state_t {IDLE, REQ, PEND, STALL};
  - default constants PC_RESET_ADDR and PC_STEP.
- No sub-module; a single flat FSM plus datapath is natural at this size.

Test Plan:
- Reset, stall_i=0, fetch_ready_i=1 -> valid rises one cycle after IDLE; addrs 0x0, 0x4, 0x8 on consecutive cycles; kill never asserted.
- REQ at 0x10, fetch_ready_i=0 for 3 cycles, jump_en_i=1 to 0x200 in first cycle -> addr holds 0x10 in PEND; after ready=1 the next addr is 0x200; kill pulses after the jump cycle and again after the 0x10 accept.
- Accepted request at 0x20 while stall_i=1 -> valid=0, addr=0x24; jump to 0x80 during stall -> addr=0x80; stall_i=0 -> valid=1 at 0x80 one cycle later; kill pulses once.
- PEND with two jumps, 0x100 then 0x300, before accept -> post-accept addr=0x300.
- WIDTH=32, addr 0xFFFF_FFFC accepted -> next addr 0x0000_0000.
- PC_ALIGN_CHK_EN defined, jump to 0x102 -> misalign_o=1 one cycle; sequential addr continues; no kill.
